vp_pack_stream: RTL and testbench
=================================

// Module: vp_pack_stream
// PURPOSE
//  Parametrised successor of the valid-pair encoder. Scans a sparse weight row (valid flags),
//  gathers each valid weight with its IA operand (indexed by pos) and packs the pairs into
//  LANES-wide bundles. Two internal banks ping-pong; bundles leave in order over a valid/ready
//  stream with backpressure. Sits between weight-buffer decode and the MAC array.
// PARAMETERS
//  W_LEN      32  weight entries per row
//  IA_CH      64  IA channels addressable by pos
//  LANES      3   pairs per output bundle
//  LOOKAHEAD  3   window entries examined per cycle (>=1)
//  DATA_W     16  signed weight / IA width
// PORTS
//  i_clk          in   1                     clock
//  i_rst_n        in   1                     async reset, active-low
//  i_start        in   1                     begin row; sampled in IDLE only
//  i_w_len        in   $clog2(W_LEN)+1       valid row length (0..W_LEN)
//  i_valid_buf    in   [W_LEN] x 1           entry valid flag
//  i_pos_buf      in   [W_LEN] x $clog2(IA_CH)  IA index of entry
//  i_addr_buf     in   [W_LEN] x addr_t      output address of entry
//  i_w_data       in   [W_LEN] x DATA_W      signed weight
//  i_ia_data      in   [IA_CH] x DATA_W      signed IA vector
//  o_valid        out  1                     bundle on outputs
//  i_ready        in   1                     consumer accepts when o_valid&&i_ready
//  o_w / o_ia     out  [LANES] x DATA_W      bundle weights / IA (zero in empty lanes)
//  o_addr         out  [LANES] x addr_t      addresses (zero in empty lanes)
//  o_lane_mask    out  LANES                 1 = lane holds a real pair
//  o_last         out  1                     bundle is final of row
//  o_busy         out  1                     not IDLE
//  o_finish       out  1                     1-cycle pulse after last bundle accepted
// BEHAVIOUR
//  - Reset: state IDLE, idx=0, both banks empty/zeroed, all outputs 0.
//  - States: IDLE -> SCAN (i_start) -> FLUSH (idx>=i_w_len) -> DRAIN -> IDLE (finish).
//  - i_start while not IDLE ignored. Inputs must be stable from i_start until o_finish.
//  - SCAN, per cycle: window idx..idx+LOOKAHEAD-1; entries >= i_w_len treated invalid (no
//    out-of-range array reads). Lowest valid entry k written to fill bank at wpos, idx<=k+1,
//    wpos++. No valid in window: idx<=idx+LOOKAHEAD. At most one pair per cycle.
//  - Bank full (wpos==LANES-1 written): bank marked ready, fill switches to other bank, wpos=0.
//    If other bank still ready/unsent: SCAN stalls (idx, wpos hold) until it drains.
//  - FLUSH: partial bank (wpos>0) marked ready with unused lanes zeroed and mask cleared;
//    wpos==0 emits nothing extra. Final emitted bundle has o_last=1.
//  - i_w_len==0 or no valid entries: no bundle; o_finish pulses 1 cycle after FLUSH.
//  - Output: oldest ready bank presented; data/mask/last stable while o_valid&&!i_ready.
//    Bank freed on accept; a bank may be filled and accepted in the same cycle (no bubble).
//  - Latency: first pair written 1 cycle after i_start; bundle o_valid the cycle after its
//    last lane write. Full throughput = 1 bundle per LANES cycles with dense input.
//  - idx width $clog2(W_LEN+LOOKAHEAD)+1; no wrap. Reset mid-row aborts, no o_finish.
// CONFIGURATION
//  VP_PACK_STATS_EN defined: adds o_nz_cnt ($clog2(W_LEN)+1, pairs packed) and o_bundle_cnt
//   (same width, bundles emitted), cleared on i_start, final on o_finish.
//  Undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  vp_pkg: addr_t (logic [2:0][6:0]), state enum, DATA_W default, lane-mask type.
//  Sub-module vp_window_pick: LOOKAHEAD-wide priority encoder -> hit, offset.
// TESTING
//  1 Dense: len=6, all valid, LANES=3, i_ready=1 -> 2 bundles (0,1,2),(3,4,5), mask=111, 2nd o_last.
//  2 Sparse: len=8, valid={0,3,7} -> 1 bundle w[0],w[3],w[7], ia=ia[pos], o_last=1, finish.
//  3 Partial: len=4 all valid -> bundles (0,1,2) then (3,0,0) mask=001, o_last=1.
//  4 Backpressure: len=12 dense, i_ready=0 for 10 cycles -> SCAN stalls, no loss, order kept.
//  5 Empty: len=0 -> o_valid never 1, o_finish pulse 2 cycles after i_start.
//  6 Reset mid-row: assert i_rst_n=0 at cycle 3 -> all outputs 0, next i_start runs clean.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared types and constants for the valid-pair pack stream.
// Used by the interface, the window picker and the top.
package vp_pkg;

  localparam int VP_DATA_W = 16;
  localparam int VP_LANES  = 3;

  typedef logic [2:0][6:0]      addr_t;
  typedef logic [VP_LANES-1:0]  lane_mask_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SCAN  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/vp_pack_stream_if.sv
// Bundle stream between the pair packer (master) and the MAC array (slave).
interface vp_pack_stream_if import vp_pkg::*; #(
  parameter int LANES  = VP_LANES,
  parameter int DATA_W = VP_DATA_W
);
  logic                         o_valid;
  logic                         i_ready;
  logic [LANES-1:0][DATA_W-1:0] o_w;
  logic [LANES-1:0][DATA_W-1:0] o_ia;
  addr_t [LANES-1:0]            o_addr;
  logic [LANES-1:0]             o_lane_mask;
  logic                         o_last;

  modport master (output o_valid, o_w, o_ia, o_addr, o_lane_mask, o_last, input i_ready);
  modport slave  (input o_valid, o_w, o_ia, o_addr, o_lane_mask, o_last, output i_ready);
endinterface

// File: rtl/vp_window_pick.sv
// Priority encoder over the scan window: lowest set flag wins.
module vp_window_pick import vp_pkg::*; #(
  parameter int LOOKAHEAD = 3,
  parameter int OFF_W     = (LOOKAHEAD > 1) ? $clog2(LOOKAHEAD) : 1
) (
  input  logic [LOOKAHEAD-1:0] i_flags,
  output logic                 o_hit,
  output logic [OFF_W-1:0]     o_offset
);
  always_comb begin
    o_hit    = |i_flags;
    o_offset = '0;
    for (int i = LOOKAHEAD - 1; i >= 0; i--) begin
      if (i_flags[i]) o_offset = OFF_W'(i);
    end
  end
endmodule

// File: rtl/vp_pack_stream.sv
// Gathers valid (weight, IA, addr) pairs of a sparse row into LANES-wide bundles via two ping-pong banks.
// Optional VP_PACK_STATS_EN adds pair / bundle counters.
module vp_pack_stream import vp_pkg::*; #(
  parameter int W_LEN     = 32,
  parameter int IA_CH     = 64,
  parameter int LANES     = 3,
  parameter int LOOKAHEAD = 3,
  parameter int DATA_W    = VP_DATA_W
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic [$clog2(W_LEN):0]               i_w_len,
  input  logic [W_LEN-1:0]                     i_valid_buf,
  input  logic [W_LEN-1:0][$clog2(IA_CH)-1:0]  i_pos_buf,
  input  addr_t [W_LEN-1:0]                    i_addr_buf,
  input  logic [W_LEN-1:0][DATA_W-1:0]         i_w_data,
  input  logic [IA_CH-1:0][DATA_W-1:0]         i_ia_data,
  vp_pack_stream_if.master                     m_if,
  output logic                                 o_busy,
  output logic                                 o_finish
`ifdef VP_PACK_STATS_EN
  ,
  output logic [$clog2(W_LEN):0]               o_nz_cnt,
  output logic [$clog2(W_LEN):0]               o_bundle_cnt
`endif
);
  localparam int LEN_W = $clog2(W_LEN) + 1;
  localparam int IDX_W = $clog2(W_LEN + LOOKAHEAD) + 1;
  localparam int KW    = (W_LEN > 1) ? $clog2(W_LEN) : 1;
  localparam int PW    = $clog2(IA_CH);
  localparam int WP_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int OFF_W = (LOOKAHEAD > 1) ? $clog2(LOOKAHEAD) : 1;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [WP_W-1:0]                     wpos_q, wpos_d;
  logic                                fill_q, fill_d, rd_q, rd_d;
  logic [1:0]                          ready_q, ready_d, last_q, last_d;
  logic [1:0][LANES-1:0][DATA_W-1:0]   bank_w_q, bank_w_d, bank_ia_q, bank_ia_d;
  addr_t [1:0][LANES-1:0]              bank_addr_q, bank_addr_d;
  logic [1:0][LANES-1:0]               bank_mask_q, bank_mask_d;
  logic                                finish_q, finish_d;

  logic [IDX_W-1:0]     len_ext, k_full;
  logic [KW-1:0]        k_sel;
  logic [PW-1:0]        pos_sel;
  logic [LOOKAHEAD-1:0] win_flags;
  logic [W_LEN-1:0]     rest_flags;
  logic [OFF_W-1:0]     pick_off;
  logic                 pick_hit, more_after, pres, accept, can_write, pair_wr;

  assign len_ext = IDX_W'(i_w_len);

  // Entries past the row length (or past the buffer) never qualify and never index out of range.
  for (genvar gi = 0; gi < LOOKAHEAD; gi++) begin : g_win
    logic [IDX_W-1:0] ent;
    assign ent           = idx_q + IDX_W'(gi);
    assign win_flags[gi] = (ent < len_ext) && i_valid_buf[(ent < IDX_W'(W_LEN)) ? ent[KW-1:0] : '0];
  end

  vp_window_pick #(.LOOKAHEAD(LOOKAHEAD), .OFF_W(OFF_W)) u_pick (
    .i_flags  (win_flags),
    .o_hit    (pick_hit),
    .o_offset (pick_off)
  );

  assign k_full  = idx_q + IDX_W'(pick_off);
  assign k_sel   = k_full[KW-1:0];
  assign pos_sel = i_pos_buf[k_sel];

  // A bank completed while later valid entries remain cannot be the row's last bundle.
  for (genvar gi = 0; gi < W_LEN; gi++) begin : g_rest
    assign rest_flags[gi] = i_valid_buf[gi] && (IDX_W'(gi) < len_ext) && (IDX_W'(gi) > k_full);
  end
  assign more_after = |rest_flags;

  assign pres      = ready_q[rd_q];
  assign accept    = pres && m_if.i_ready;
  assign can_write = !ready_q[fill_q] || (accept && (rd_q == fill_q));
  assign pair_wr   = (state_q == ST_SCAN) && (idx_q < len_ext) && can_write && pick_hit;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wpos_d      = wpos_q;
    fill_d      = fill_q;
    rd_d        = rd_q;
    ready_d     = ready_q;
    last_d      = last_q;
    bank_w_d    = bank_w_q;
    bank_ia_d   = bank_ia_q;
    bank_addr_d = bank_addr_q;
    bank_mask_d = bank_mask_q;
    finish_d    = 1'b0;

    if (accept) begin
      ready_d[rd_q] = 1'b0;
      rd_d          = ~rd_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          wpos_d  = '0;
        end
      end
      ST_SCAN: begin
        if (idx_q >= len_ext) begin
          state_d = ST_FLUSH;
        end else if (can_write) begin
          if (pick_hit) begin
            if (wpos_q == '0) begin
              bank_w_d[fill_q]    = '0;
              bank_ia_d[fill_q]   = '0;
              bank_addr_d[fill_q] = '0;
              bank_mask_d[fill_q] = '0;
              last_d[fill_q]      = 1'b0;
            end
            bank_w_d[fill_q][wpos_q]    = i_w_data[k_sel];
            bank_ia_d[fill_q][wpos_q]   = i_ia_data[pos_sel];
            bank_addr_d[fill_q][wpos_q] = i_addr_buf[k_sel];
            bank_mask_d[fill_q][wpos_q] = 1'b1;
            idx_d = k_full + IDX_W'(1);
            if (wpos_q == WP_W'(LANES - 1)) begin
              ready_d[fill_q] = 1'b1;
              last_d[fill_q]  = !more_after;
              fill_d          = ~fill_q;
              wpos_d          = '0;
            end else begin
              wpos_d = wpos_q + WP_W'(1);
            end
          end else begin
            idx_d = idx_q + IDX_W'(LOOKAHEAD);
          end
        end
      end
      ST_FLUSH: begin
        if (wpos_q != '0) begin
          ready_d[fill_q] = 1'b1;
          last_d[fill_q]  = 1'b1;
          fill_d          = ~fill_q;
          wpos_d          = '0;
        end
        if (ready_d == 2'b00) begin
          state_d  = ST_IDLE;
          finish_d = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ready_d == 2'b00) begin
          state_d  = ST_IDLE;
          finish_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wpos_q      <= '0;
      fill_q      <= 1'b0;
      rd_q        <= 1'b0;
      ready_q     <= '0;
      last_q      <= '0;
      bank_w_q    <= '0;
      bank_ia_q   <= '0;
      bank_addr_q <= '0;
      bank_mask_q <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wpos_q      <= wpos_d;
      fill_q      <= fill_d;
      rd_q        <= rd_d;
      ready_q     <= ready_d;
      last_q      <= last_d;
      bank_w_q    <= bank_w_d;
      bank_ia_q   <= bank_ia_d;
      bank_addr_q <= bank_addr_d;
      bank_mask_q <= bank_mask_d;
      finish_q    <= finish_d;
    end
  end

  assign m_if.o_valid     = pres;
  assign m_if.o_w         = pres ? bank_w_q[rd_q]    : '0;
  assign m_if.o_ia        = pres ? bank_ia_q[rd_q]   : '0;
  assign m_if.o_addr      = pres ? bank_addr_q[rd_q] : '0;
  assign m_if.o_lane_mask = pres ? bank_mask_q[rd_q] : '0;
  assign m_if.o_last      = pres && last_q[rd_q];
  assign o_busy           = (state_q != ST_IDLE);
  assign o_finish         = finish_q;

`ifdef VP_PACK_STATS_EN
  logic [LEN_W-1:0] nz_cnt_q, nz_cnt_d, bundle_cnt_q, bundle_cnt_d;

  always_comb begin
    nz_cnt_d     = nz_cnt_q;
    bundle_cnt_d = bundle_cnt_q;
    if ((state_q == ST_IDLE) && i_start) begin
      nz_cnt_d     = '0;
      bundle_cnt_d = '0;
    end else begin
      if (pair_wr) nz_cnt_d     = nz_cnt_q + LEN_W'(1);
      if (accept)  bundle_cnt_d = bundle_cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nz_cnt_q     <= '0;
      bundle_cnt_q <= '0;
    end else begin
      nz_cnt_q     <= nz_cnt_d;
      bundle_cnt_q <= bundle_cnt_d;
    end
  end

  assign o_nz_cnt     = nz_cnt_q;
  assign o_bundle_cnt = bundle_cnt_q;
`endif

endmodule

// File: tb/tb_vp_pack_stream.sv
// Scoreboard bench for vp_pack_stream: directed rows, a mid-row reset, then random rows with random backpressure.
module tb_vp_pack_stream;
  import vp_pkg::*;

  localparam int W_LEN     = 32;
  localparam int IA_CH     = 64;
  localparam int LANES     = 3;
  localparam int LOOKAHEAD = 3;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = $clog2(W_LEN) + 1;
  localparam int PW        = $clog2(IA_CH);

  typedef struct packed {
    logic [LANES-1:0][DATA_W-1:0] w;
    logic [LANES-1:0][DATA_W-1:0] ia;
    addr_t [LANES-1:0]            addr;
    logic [LANES-1:0]             mask;
    logic                         last;
  } bundle_t;

  logic                         clk   = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic [LEN_W-1:0]             w_len;
  logic [W_LEN-1:0]             valid_buf;
  logic [W_LEN-1:0][PW-1:0]     pos_buf;
  addr_t [W_LEN-1:0]            addr_buf;
  logic [W_LEN-1:0][DATA_W-1:0] w_data;
  logic [IA_CH-1:0][DATA_W-1:0] ia_data;
  logic                         busy, finish;
`ifdef VP_PACK_STATS_EN
  logic [LEN_W-1:0]             nz_cnt, bundle_cnt;
`endif

  vp_pack_stream_if #(.LANES(LANES), .DATA_W(DATA_W)) s_if ();

  always #5 clk = ~clk;

  vp_pack_stream #(
    .W_LEN(W_LEN), .IA_CH(IA_CH), .LANES(LANES), .LOOKAHEAD(LOOKAHEAD), .DATA_W(DATA_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_w_len     (w_len),
    .i_valid_buf (valid_buf),
    .i_pos_buf   (pos_buf),
    .i_addr_buf  (addr_buf),
    .i_w_data    (w_data),
    .i_ia_data   (ia_data),
    .m_if        (s_if),
    .o_busy      (busy),
    .o_finish    (finish)
`ifdef VP_PACK_STATS_EN
    ,
    .o_nz_cnt     (nz_cnt),
    .o_bundle_cnt (bundle_cnt)
`endif
  );

  int      n_cmp = 0;
  int      n_err = 0;
  int      n_acc = 0;
  bundle_t exp_q[$];
  bundle_t mon_e;
  logic    stall_prev;
  logic [LANES-1:0][DATA_W-1:0] w_prev;
  logic [LANES-1:0]             mask_prev;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_row(input int len, input logic [W_LEN-1:0] vpat);
    logic [31:0] r;
    w_len     = LEN_W'(len);
    valid_buf = vpat;
    for (int j = 0; j < W_LEN; j++) begin
      r = $urandom; pos_buf[j]  = r[PW-1:0];
      r = $urandom; addr_buf[j] = r[20:0];
      r = $urandom; w_data[j]   = r[DATA_W-1:0];
    end
    for (int c = 0; c < IA_CH; c++) begin
      r = $urandom; ia_data[c] = r[DATA_W-1:0];
    end
  endtask

  // Reference packing: valid entries below the length, in order, LANES per bundle.
  task automatic push_expected(output int npairs, output int nbund);
    bundle_t e;
    int lane;
    e = '0; lane = 0; npairs = 0; nbund = 0;
    for (int j = 0; j < int'(w_len); j++) begin
      if (valid_buf[j]) begin
        e.w[lane]    = w_data[j];
        e.ia[lane]   = ia_data[pos_buf[j]];
        e.addr[lane] = addr_buf[j];
        e.mask[lane] = 1'b1;
        lane++; npairs++;
        if (lane == LANES) begin
          exp_q.push_back(e); nbund++; e = '0; lane = 0;
        end
      end
    end
    if (lane > 0) begin
      exp_q.push_back(e); nbund++;
    end
    if (nbund > 0) begin
      e = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  initial begin : monitor
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_prev) begin
          check("hold_valid", 64'(s_if.o_valid), 64'd1);
          check("hold_w", 64'(s_if.o_w), 64'(w_prev));
          check("hold_mask", 64'(s_if.o_lane_mask), 64'(mask_prev));
        end
        if (s_if.o_valid && s_if.i_ready) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            check("extra_bundle", 64'd1, 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("w", 64'(s_if.o_w), 64'(mon_e.w));
            check("ia", 64'(s_if.o_ia), 64'(mon_e.ia));
            check("addr", 64'(s_if.o_addr), 64'(mon_e.addr));
            check("mask", 64'(s_if.o_lane_mask), 64'(mon_e.mask));
            check("last", 64'(s_if.o_last), 64'(mon_e.last));
            $display("[%0t] bundle mask=%b last=%b w=%h", $time, s_if.o_lane_mask, s_if.o_last, s_if.o_w);
          end
        end
        stall_prev = s_if.o_valid && !s_if.i_ready;
        w_prev     = s_if.o_w;
        mask_prev  = s_if.o_lane_mask;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Caller is just after a rising edge. Cycle numbers count falling edges after the edge that samples i_start.
  task automatic run_row(input string name, input int len, input logic [W_LEN-1:0] vpat,
                         input int rdy_hold, input bit rnd_rdy, output int first_v, output int fin_cyc);
    int npairs, nbund, cyc;
    bit done;
    load_row(len, vpat);
    push_expected(npairs, nbund);
    n_acc = 0;
    s_if.i_ready = (rdy_hold == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; first_v = -1; fin_cyc = -1; done = 1'b0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (first_v < 0 && s_if.o_valid) first_v = cyc;
      if (finish) begin
        done = 1'b1; fin_cyc = cyc;
      end
      @(posedge clk); #1;
      s_if.i_ready = (cyc >= rdy_hold) && (!rnd_rdy || ($urandom_range(0, 9) < 7));
    end
    s_if.i_ready = 1'b1;
    check({name, "_finish_seen"}, 64'(done), 64'd1);
    @(negedge clk);
    check({name, "_finish_pulse"}, 64'(finish), 64'd0);
    check({name, "_idle"}, 64'(busy), 64'd0);
    check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
    check({name, "_bundles"}, 64'(n_acc), 64'(nbund));
`ifdef VP_PACK_STATS_EN
    check({name, "_nz_cnt"}, 64'(nz_cnt), 64'(npairs));
    check({name, "_bundle_cnt"}, 64'(bundle_cnt), 64'(nbund));
`endif
    $display("[%0t] row %s len=%0d pairs=%0d bundles=%0d finish_cycle=%0d", $time, name, len, npairs, nbund, fin_cyc);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int fv, fc;
    logic [W_LEN-1:0] vp;
    s_if.i_ready = 1'b1;
    load_row(0, '0);

    @(negedge clk);
    check("rst_valid", 64'(s_if.o_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_mask", 64'(s_if.o_lane_mask), 64'd0);
    check("rst_last", 64'(s_if.o_last), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_row("dense", 6, '1, 0, 1'b0, fv, fc);
    check("dense_first_valid", 64'(fv), 64'd4);
    run_row("sparse", 8, 32'h0000_0289, 0, 1'b0, fv, fc);
    run_row("partial", 4, '1, 0, 1'b0, fv, fc);
    run_row("backpressure", 12, '1, 10, 1'b0, fv, fc);
    run_row("empty", 0, '1, 0, 1'b0, fv, fc);
    check("empty_no_valid", 64'(fv), -64'sd1);
    check("empty_finish_cycle", 64'(fc), 64'd3);

    // Abort a dense row right after its first bundle appears.
    load_row(12, '1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(s_if.o_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_finish", 64'(finish), 64'd0);
    check("midrst_w", 64'(s_if.o_w), 64'd0);
    check("midrst_mask", 64'(s_if.o_lane_mask), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_no_finish", 64'(finish), 64'd0);
    @(posedge clk); #1;
    run_row("after_reset", 6, '1, 0, 1'b0, fv, fc);
    check("after_reset_first_valid", 64'(fv), 64'd4);

    run_row("full_len", 32, '1, 0, 1'b1, fv, fc);
    for (int r = 0; r < 6; r++) begin
      vp = $urandom & $urandom;
      run_row("random", $urandom_range(0, W_LEN), vp, $urandom_range(0, 4), 1'b1, fv, fc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
